mul_issue_scheduler: RTL

//  Issue scheduler for the shared multi-cycle mul/div unit (op_type mul: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).

---
 rtl/mul_issue_scheduler.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mul_issue_scheduler.sv
// Issue scheduler for the shared multi-cycle mul/div unit.
// Round-robin picks one ready mul RS entry, starts the unit, counts its fixed
// latency and drives the mul CDB channel for exactly one cycle per result.
// A ROB flush squashes whatever is in flight and blocks issue that cycle.
module mul_issue_scheduler #(
  parameter int NUM_RS    = 4,
  parameter int MUL_LAT   = 3,
  parameter int DIV_LAT   = 33,
  parameter int ROB_IDX_W = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [NUM_RS-1:0]             rs_ready,
  input  logic [3*NUM_RS-1:0]           rs_multop,
  input  logic [ROB_IDX_W*NUM_RS-1:0]   rs_rob_idx,
  input  logic [5*NUM_RS-1:0]           rs_rd_addr,
  output logic [NUM_RS-1:0]             grant,
  output logic                          fu_start,
  output logic [$clog2(NUM_RS)-1:0]     fu_sel,
  output logic [2:0]                    fu_op,
  input  logic [31:0]                   fu_result,
  output logic                          busy,
  output logic                          cdb_valid,
  output logic [31:0]                   cdb_data,
  output logic [ROB_IDX_W-1:0]          cdb_rob_idx,
  output logic [4:0]                    cdb_rd_addr
);

  localparam int SEL_W   = $clog2(NUM_RS);
  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state, state_nxt;
  logic [SEL_W-1:0]     rr_ptr, rr_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [ROB_IDX_W-1:0] tag_rob;
  logic [4:0]           tag_rd;

  logic                 found;
  logic [SEL_W-1:0]     win;
  logic                 issue;
  logic [2:0]           win_op;
  logic [CNT_W-1:0]     lat_m1;

  // Rotating priority scan: first ready entry starting at rr_ptr.
  always_comb begin
    int idx;
    logic [SEL_W-1:0] cand;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_RS) idx = idx - NUM_RS;
      cand = SEL_W'(idx);
      if (!found && rs_ready[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Issue is only possible with the unit free, no flush, and out of reset;
  // gating on rst_n keeps the combinational outputs quiet during reset.
  assign issue    = rst_n && !flush && (state != BUSY) && found;
  assign win_op   = rs_multop[win*3 +: 3];
  assign lat_m1   = win_op[2] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);

  assign grant    = issue ? ({{(NUM_RS-1){1'b0}}, 1'b1} << win) : '0;
  assign fu_start = issue;
  assign fu_sel   = issue ? win : '0;
  assign fu_op    = issue ? win_op : 3'b000;

  // Next-state, latency counter and round-robin pointer update.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rr_nxt    = rr_ptr;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        BUSY: begin
          cnt_nxt = cnt - 1'b1;
          if (cnt == CNT_W'(1)) state_nxt = DONE;
        end
        default: begin
          // IDLE and DONE share the issue window (DONE allows back-to-back).
          if (issue) begin
            state_nxt = BUSY;
            cnt_nxt   = lat_m1;
            rr_nxt    = (win == SEL_W'(NUM_RS - 1)) ? '0 : win + 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      endcase
    end
  end

  // State register, counter, pointer, and tags captured at issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rr_ptr  <= '0;
      tag_rob <= '0;
      tag_rd  <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      rr_ptr <= rr_nxt;
      if (issue) begin
        tag_rob <= rs_rob_idx[win*ROB_IDX_W +: ROB_IDX_W];
        tag_rd  <= rs_rd_addr[win*5 +: 5];
      end
    end
  end

  // CDB broadcast only in DONE; a same-cycle flush suppresses the valid.
  assign busy        = (state == BUSY);
  assign cdb_valid   = (state == DONE) && !flush;
  assign cdb_data    = (state == DONE) ? fu_result : 32'd0;
  assign cdb_rob_idx = (state == DONE) ? tag_rob : '0;
  assign cdb_rd_addr = (state == DONE) ? tag_rd : 5'd0;

endmodule
